// File: rtl/fifo_pkg.sv
// fifo_pkg: constants, output-stage states and pointer code conversions shared by both FIFO controllers
package fifo_pkg;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int GW = 32;
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } ostate_e;
    // Narrower pointers are zero-extended to GW bits, so callers truncate the result back to their width
    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction
    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: storage array read port, pointer exchange and FWFT output stream of the read side
interface fifo_rd_ctrl_if #(
    parameter int DW = fifo_pkg::DW,
    parameter int AW = fifo_pkg::AW
);
    logic [AW:0]   wptr_gray_sync;
    logic [DW-1:0] rdata;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr_gray;
    logic          rempty;
    logic [AW:0]   rlevel;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    modport master (
        input  wptr_gray_sync, rdata, dout_ready,
        output raddr, rptr_gray, rempty, rlevel, dout, dout_valid
    );
    modport slave (
        output wptr_gray_sync, rdata, dout_ready,
        input  raddr, rptr_gray, rempty, rlevel, dout, dout_valid
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read pointer, empty/level status and first-word-fall-through output register of the FIFO
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int dw = DW,
    parameter int aw = AW
) (
    input logic            clk,
    input logic            rst_n,
    fifo_rd_ctrl_if.master bus
);
    localparam int PW = aw + 1;
    ostate_e       r_state;
    ostate_e       w_state_nxt;
    logic [aw:0]   r_bin;
    logic [aw:0]   r_gray;
    logic [aw:0]   w_bin_nxt;
    logic [aw:0]   w_wbin;
    logic [dw-1:0] r_dout;
    logic          w_empty;
    logic          w_pop;
    assign w_bin_nxt      = r_bin + 1'b1;
    assign w_wbin         = PW'(gray2bin(GW'(bus.wptr_gray_sync)));
    assign w_empty        = r_gray == bus.wptr_gray_sync;
    assign w_pop          = !w_empty && (r_state == IDLE || bus.dout_ready);
    assign bus.raddr      = r_bin[aw-1:0];
    assign bus.rptr_gray  = r_gray;
    assign bus.rempty     = w_empty;
    assign bus.rlevel     = w_wbin - r_bin;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_state == HOLD;
    // Output-stage state register: HOLD means dout carries an unaccepted word
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end
    // A pop always lands a word in the output register; an accept without refill empties it
    always_comb begin
        w_state_nxt = r_state;
        if (w_pop)                 w_state_nxt = HOLD;
        else if (bus.dout_ready)   w_state_nxt = IDLE;
    end
    // Read pointer advances once per pop, binary and Gray copies kept in lockstep
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else if (w_pop) begin
            r_bin  <= w_bin_nxt;
            r_gray <= PW'(bin2gray(GW'(w_bin_nxt)));
        end
    end
    // Capture the combinational array read on pop; otherwise hold the last word
    always_ff @(posedge clk) begin
        if (!rst_n)     r_dout <= '0;
        else if (w_pop) r_dout <= bus.rdata;
    end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed and randomized stimulus against a queue-based model of the read side
module tb_fifo_rd_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] mem [256];
    logic [15:0] q [$];
    logic [8:0] wcnt;
    logic [8:0] m_rd;
    logic [15:0] m_dout;
    logic m_valid;
    logic m_live = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    fifo_rd_ctrl_if #(.DW(16), .AW(8)) bus ();
    fifo_rd_ctrl #(.dw(16), .aw(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    assign bus.rdata = mem[bus.raddr];

    function automatic logic [8:0] g(input logic [8:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        mem[wcnt[7:0]] = d;
        q.push_back(d);
        wcnt = wcnt + 9'd1;
        bus.wptr_gray_sync = g(wcnt);
    endtask

    task automatic wipe();
        rst_n = 1'b0;
        wcnt = '0;
        bus.wptr_gray_sync = '0;
        q.delete();
    endtask

    // Reference: the array is the queue q; the output register takes its head whenever it is free or being accepted
    always @(posedge clk) begin
        if (!rst_n) begin
            m_live = 1'b1;
            m_valid = 1'b0;
            m_dout = '0;
            m_rd = '0;
            q.delete();
        end else if (q.size() != 0 && (!m_valid || bus.dout_ready)) begin
            m_dout = q.pop_front();
            m_valid = 1'b1;
            m_rd = m_rd + 9'd1;
        end else if (m_valid && bus.dout_ready) begin
            m_valid = 1'b0;
        end
        assert (q.size() <= 256) else $error("illegal stimulus: array over capacity");
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
            chk("dout", 32'(bus.dout), 32'(m_dout));
            chk("raddr", 32'(bus.raddr), 32'(m_rd[7:0]));
            chk("rptr_gray", 32'(bus.rptr_gray), 32'(g(m_rd)));
            chk("rempty", 32'(bus.rempty), 32'(q.size() == 0));
            chk("rlevel", 32'(bus.rlevel), 32'(q.size()));
        end
    end

    initial begin
        wcnt = '0;
        bus.wptr_gray_sync = '0;
        bus.dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.dout_valid), 32'h0);
        chk("rst_dout", 32'(bus.dout), 32'h0);
        chk("rst_raddr", 32'(bus.raddr), 32'h0);
        chk("rst_rptr", 32'(bus.rptr_gray), 32'h000);
        chk("rst_empty", 32'(bus.rempty), 32'h1);
        chk("rst_level", 32'(bus.rlevel), 32'h0);
        #1 rst_n = 1'b1;
        push(16'hA5A5);
        @(negedge clk);
        chk("one_dout", 32'(bus.dout), 32'hA5A5);
        chk("one_valid", 32'(bus.dout_valid), 32'h1);
        chk("one_raddr", 32'(bus.raddr), 32'h1);
        chk("one_rptr", 32'(bus.rptr_gray), 32'h001);
        chk("one_empty", 32'(bus.rempty), 32'h1);
        #1 bus.dout_ready = 1'b1;
        @(negedge clk);
        chk("one_drain", 32'(bus.dout_valid), 32'h0);
        #1 bus.dout_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            push(16'(k));
            @(negedge clk);
            #1;
        end
        chk("bp_dout", 32'(bus.dout), 32'h0001);
        chk("bp_valid", 32'(bus.dout_valid), 32'h1);
        chk("bp_level", 32'(bus.rlevel), 32'h2);
        chk("bp_raddr", 32'(bus.raddr), 32'h2);
        bus.dout_ready = 1'b1;
        @(negedge clk);
        chk("bp_w2", 32'(bus.dout), 32'h0002);
        @(negedge clk);
        chk("bp_w3", 32'(bus.dout), 32'h0003);
        chk("bp_w3v", 32'(bus.dout_valid), 32'h1);
        @(negedge clk);
        chk("bp_end", 32'(bus.dout_valid), 32'h0);
        #1 bus.dout_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            push(16'h0100 + 16'(k));
            @(negedge clk);
            #1;
        end
        chk("mid_level", 32'(bus.rlevel), 32'h5);
        chk("mid_valid", 32'(bus.dout_valid), 32'h1);
        wipe();
        @(negedge clk);
        chk("mid_valid0", 32'(bus.dout_valid), 32'h0);
        chk("mid_dout0", 32'(bus.dout), 32'h0);
        chk("mid_rptr0", 32'(bus.rptr_gray), 32'h000);
        chk("mid_empty", 32'(bus.rempty), 32'h1);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 257; k++) begin
            push(16'(k * 3 + 7));
            @(negedge clk);
            #1;
        end
        chk("full_level", 32'(bus.rlevel), 32'h100);
        chk("full_empty", 32'(bus.rempty), 32'h0);
        chk("full_rptr", 32'(bus.rptr_gray), 32'h001);
        bus.dout_ready = 1'b1;
        repeat (256) @(negedge clk);
        chk("full_drained", 32'(bus.rempty), 32'h1);
        chk("full_last", 32'(bus.dout), 32'(16'(256 * 3 + 7)));
        @(negedge clk);
        chk("full_done", 32'(bus.dout_valid), 32'h0);
        #1 wipe();
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 512; i++) begin
            push(16'($urandom()));
            @(negedge clk);
            if (i == 255) chk("wrap_raddr255", 32'(bus.raddr), 32'hFF);
            if (i == 256) begin
                chk("wrap_raddr0", 32'(bus.raddr), 32'h0);
                chk("wrap_rptr256", 32'(bus.rptr_gray), 32'h180);
            end
            #1;
        end
        chk("wrap_rptr512", 32'(bus.rptr_gray), 32'h000);
        for (int i = 0; i < 3000; i++) begin
            int pp;
            int rp;
            pp = (i / 500) % 2 == 0 ? 80 : 30;
            rp = (i / 250) % 3 == 0 ? 20 : 85;
            bus.dout_ready = $urandom_range(0, 99) < rp;
            if (q.size() < 256 && $urandom_range(0, 99) < pp) push(16'($urandom()));
            @(negedge clk);
            #1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the FIFO storage array. It owns the read pointer and drives the array's `raddr`. It takes the combinational `rdata` back and presents it as a first-word-fall-through valid/ready stream. It also exports a Gray-coded read pointer to the write side and computes empty status and level from a write pointer that is already synchronized into this clock domain.

## Interface
- `dw`, default 16: data width; must match the storage array.
- `aw`, default 8: address width; array depth is 2^aw, so 256 by default.

Ports:
- `clk` input, 1 bit: read-domain clock, rising edge.
- `rst_n` input, 1 bit: reset, **synchronous, active-low**, one clock.
- `wptr_gray_sync` input, `aw+1` bits: write pointer in Gray code, already synchronized to `clk`.
- `rdata` input, `dw` bits: storage array read data, combinational on `raddr`.
- `raddr` output, `aw` bits: storage array read address.
- `rptr_gray` output, `aw+1` bits: registered read pointer in Gray code, for synchronization into the write domain.
- `rempty` output, 1 bit: storage array holds no unread words.
- `rlevel` output, `aw+1` bits: number of unread words in the storage array; excludes the output register.
- `dout` output, `dw` bits: stream data.
- `dout_valid` output, 1 bit: `dout` holds a valid word.
- `dout_ready` input, 1 bit: consumer accepts `dout` this cycle.

## Operation
- **State:**
  - `rbin[aw:0]`: binary read pointer.
  - `rgray[aw:0]`: Gray copy, equal to bin2gray(`rbin`).
  - Output register `dout` / `dout_valid`.
- **Output-stage state machine**, tracked by `dout_valid`:
  - `IDLE` (0) → `HOLD` (1) on `pop`.
  - `HOLD` → `HOLD` on `pop`, or when `dout_ready`=0.
  - `HOLD` → `IDLE` when `dout_ready`=1 and no `pop`.
- **Combinational signals:**
  - `raddr` = `rbin[aw-1:0]`.
  - `rptr_gray` = `rgray`.
  - `rempty` = (`rgray` == `wptr_gray_sync`).
  - `rlevel` = gray2bin(`wptr_gray_sync`) − `rbin`, modulo 2^(aw+1).
- **Pop condition:** `pop` = !`rempty` && (!`dout_valid` || `dout_ready`).
- **On `pop`:**
  - `dout` ← `rdata`.
  - `dout_valid` ← 1.
  - `rbin` ← `rbin`+1.
  - `rgray` ← bin2gray(`rbin`+1).
- **Else if `dout_valid` && `dout_ready`:** `dout_valid` ← 0; `dout` keeps its value.
- **Stability:** while `dout_valid`=1 and `dout_ready`=0, `dout` is held and no pointer moves.
- **Simultaneous accept and refill:** `dout_ready`=1, `dout_valid`=1, `rempty`=0 → the new word loads in the same cycle. Throughput is one word per clock.
- **Wrap:**
  - `rbin` wraps from 2^(aw+1)−1 to 0.
  - `raddr` wraps from 2^aw−1 to 0.
  - The extra MSB distinguishes full from empty.
  - `rlevel` = 2^aw means the array is full.
- **Reset values:** `rbin`=0, `rgray`=0, `dout`=0, `dout_valid`=0. As a consequence `raddr`=0 and `rptr_gray`=0. `rempty`/`rlevel` follow `wptr_gray_sync`.
- **Reset mid-operation:**
  - Any held word is discarded.
  - Pointers return to 0.
  - The write side must be reset in the same window.
  - No reset-time handshake.
- **Illegal input:** `wptr_gray_sync` moving more than one Gray step per cycle, or `rlevel` > 2^aw, is illegal. The block does not detect it. The bench asserts against it.

## Timing
- `rdata` is sampled in the same cycle that `raddr` presents; the array read is combinational.
- **Latency:** `wptr_gray_sync` advancing off `rgray` with the output register free gives `dout_valid`=1 on the next rising edge.
- `rptr_gray` changes only at clock edges and by at most one Gray bit per cycle, so it is safe for the write-side synchronizer.
- `rempty` and `rlevel` are combinational from registered values. They are not used as inputs to any other clock domain.

## Structure
- Shared package `fifo_pkg` contains:
  - `bin2gray` and `gray2bin` functions, parameterized by width. The write-side controller uses the same functions.
  - Default `DW`=16 and `AW`=8 constants.
- No sub-module: pointer logic and the output register are one process each. The synchronizer stays outside this block.

## Test plan
All scenarios use `aw`=8, `dw`=16.

- **Reset:** `rst_n`=0 for 2 clocks, `wptr_gray_sync`=0 → `dout_valid`=0, `dout`=0, `raddr`=0, `rptr_gray`=9'h000, `rempty`=1, `rlevel`=0.
- **Single word:** mem[0]=16'hA5A5; `wptr_gray_sync` 0→9'h001 → next edge `dout`=16'hA5A5, `dout_valid`=1, `raddr`=1, `rptr_gray`=9'h001, `rempty`=1.
- **Backpressure:**
  - Stimulus: words 16'h0001, 16'h0002, 16'h0003; `wptr_gray_sync`=bin2gray(3); `dout_ready`=0.
  - Required: `dout`=16'h0001 held, `rbin`=1, `rlevel`=2.
  - Then `dout_ready`=1 → words appear in order on consecutive cycles, `dout_valid`=0 after the third.
- **Full/level:** `wptr_gray_sync`=9'h180 (binary 256) with `rbin`=0 → `rlevel`=256, `rempty`=0. With `dout_ready`=1, 256 words arrive on 256 consecutive cycles, then `rempty`=1.
- **Wrap:** stream 512 words at full rate →
  - `raddr` steps 255→0.
  - At 256 pops, `rptr_gray`=9'h180.
  - After 512 pops, `rptr_gray`=9'h000.
  - Data order intact throughout.
- **Mid-op reset:** `dout_valid`=1, `rlevel`=5, `rst_n`=0 for one clock together with `wptr_gray_sync`=0 → next edge all registers 0, `rempty`=1, no spurious `dout_valid`.
